// File: rtl/plb_cache_responder.sv
// Fully associative permission-lookaside cache answering lookups/fills on a req/gnt memory port.
// Latency 1 (one response per grant); no backpressure other than flush_i, which blocks grants.
module plb_cache_responder #(
  parameter int PLB_ENTRIES  = 8,
  parameter int SDID_WIDTH   = 6,
  parameter int SPA_WIDTH    = 34,
  parameter int ACCESS_WIDTH = 3,
  parameter int DATA_WIDTH   = 8,
  localparam int ADDR_WIDTH  = SDID_WIDTH + SPA_WIDTH + ACCESS_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    plb_cache_mem_req,
  output logic                    plb_cache_mem_gnt,
  input  logic [ADDR_WIDTH-1:0]   plb_cache_mem_addr,
  input  logic                    plb_cache_mem_we,
  input  logic [DATA_WIDTH-1:0]   plb_cache_mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] plb_cache_mem_be,
  output logic                    plb_cache_mem_valid,
  output logic [DATA_WIDTH-1:0]   plb_cache_mem_rdata,
  input  logic                    flush_i,
  output logic [31:0]             hit_count_o,
  output logic [31:0]             miss_count_o
);

  localparam int PAGE_WIDTH = SPA_WIDTH - 12;
  localparam int IDX_WIDTH  = $clog2(PLB_ENTRIES);

  logic [ACCESS_WIDTH-1:0] req_acc;
  logic [SPA_WIDTH-1:0]    req_spa;
  logic [SDID_WIDTH-1:0]   req_sdid;
  logic [PAGE_WIDTH-1:0]   req_page;

  assign req_acc  = plb_cache_mem_addr[ACCESS_WIDTH-1:0];
  assign req_spa  = plb_cache_mem_addr[ACCESS_WIDTH +: SPA_WIDTH];
  assign req_sdid = plb_cache_mem_addr[ACCESS_WIDTH+SPA_WIDTH +: SDID_WIDTH];
  assign req_page = req_spa[SPA_WIDTH-1:12];

  logic                    unused_ok;
  assign unused_ok = ^{plb_cache_mem_be, plb_cache_mem_wdata[DATA_WIDTH-1:ACCESS_WIDTH],
                       req_spa[11:0]};

  logic [PLB_ENTRIES-1:0]  ent_valid;
  logic [SDID_WIDTH-1:0]   ent_sdid [PLB_ENTRIES];
  logic [PAGE_WIDTH-1:0]   ent_page [PLB_ENTRIES];
  logic [ACCESS_WIDTH-1:0] ent_perm [PLB_ENTRIES];
  logic [IDX_WIDTH-1:0]    victim;

  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic [31:0]             hit_cnt;
  logic [31:0]             miss_cnt;

  logic                    gnt;
  logic [PLB_ENTRIES-1:0]  tag_match;
  logic [PLB_ENTRIES-1:0]  perm_ok;
  logic                    hit;
  logic                    any_match;
  logic                    all_valid;
  logic [IDX_WIDTH-1:0]    match_idx;
  logic [IDX_WIDTH-1:0]    free_idx;
  logic [IDX_WIDTH-1:0]    fill_idx;

  assign gnt = plb_cache_mem_req && !flush_i;

  always_comb begin
    tag_match = '0;
    perm_ok   = '0;
    for (int i = 0; i < PLB_ENTRIES; i++) begin
      tag_match[i] = ent_valid[i] && (ent_sdid[i] == req_sdid) && (ent_page[i] == req_page);
      perm_ok[i]   = (req_acc & ~ent_perm[i]) == '0;
    end
  end

  assign hit       = |(tag_match & perm_ok);
  assign any_match = |tag_match;
  assign all_valid = &ent_valid;

  // Descending scan so the lowest qualifying index is the one that sticks.
  always_comb begin
    match_idx = '0;
    free_idx  = '0;
    for (int i = PLB_ENTRIES - 1; i >= 0; i--) begin
      if (tag_match[i]) match_idx = IDX_WIDTH'(i);
      if (!ent_valid[i]) free_idx = IDX_WIDTH'(i);
    end
  end

  always_comb begin
    fill_idx = victim;
    if (any_match) fill_idx = match_idx;
    else if (!all_valid) fill_idx = free_idx;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_valid <= '0;
      victim    <= '0;
      for (int i = 0; i < PLB_ENTRIES; i++) begin
        ent_sdid[i] <= '0;
        ent_page[i] <= '0;
        ent_perm[i] <= '0;
      end
    end else if (flush_i) begin
      ent_valid <= '0;
      victim    <= '0;
    end else if (gnt && plb_cache_mem_we) begin
      ent_valid[fill_idx] <= 1'b1;
      ent_sdid[fill_idx]  <= req_sdid;
      ent_page[fill_idx]  <= req_page;
      ent_perm[fill_idx]  <= plb_cache_mem_wdata[ACCESS_WIDTH-1:0];
      // Pointer only moves when it actually chose the victim; wraps naturally (power of two).
      if (!any_match && all_valid) victim <= victim + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      rsp_valid <= gnt;
      rsp_rdata <= {{(DATA_WIDTH-1){1'b0}}, gnt && !plb_cache_mem_we && hit};
      if (gnt && !plb_cache_mem_we) begin
        if (hit) begin
          if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
        end else begin
          if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
        end
      end
    end
  end

  assign plb_cache_mem_gnt   = gnt;
  assign plb_cache_mem_valid = rsp_valid;
  assign plb_cache_mem_rdata = rsp_rdata;
  assign hit_count_o         = hit_cnt;
  assign miss_count_o        = miss_cnt;

endmodule

// File: tb/tb_plb_cache_responder.sv
// Directed bench for plb_cache_responder: lookups, fills, eviction, back-to-back, flush, reset.
module tb_plb_cache_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req;
  logic        gnt;
  logic [42:0] addr;
  logic        we;
  logic [7:0]  wdata;
  logic [0:0]  be;
  logic        valid;
  logic [7:0]  rdata;
  logic        flush;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  plb_cache_responder dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .plb_cache_mem_req   (req),
    .plb_cache_mem_gnt   (gnt),
    .plb_cache_mem_addr  (addr),
    .plb_cache_mem_we    (we),
    .plb_cache_mem_wdata (wdata),
    .plb_cache_mem_be    (be),
    .plb_cache_mem_valid (valid),
    .plb_cache_mem_rdata (rdata),
    .flush_i             (flush),
    .hit_count_o         (hit_count),
    .miss_count_o        (miss_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic w, input logic [5:0] sdid, input logic [33:0] spa,
                         input logic [2:0] acc, input logic [7:0] wd);
    req   = 1'b1;
    we    = w;
    addr  = {sdid, spa, acc};
    wdata = wd;
  endtask

  // One isolated transaction: grant checked mid-cycle, response checked just after the edge.
  task automatic op(input logic w, input logic [5:0] sdid, input logic [33:0] spa,
                    input logic [2:0] acc, input logic [7:0] wd, input logic [7:0] exp,
                    input string tag);
    @(posedge clk_i); #1;
    set_req(w, sdid, spa, acc, wd);
    @(negedge clk_i);
    chk({tag, "_gnt"}, 64'(gnt), 64'd1);
    @(posedge clk_i); #1;
    req = 1'b0;
    chk({tag, "_vld"}, 64'(valid), 64'd1);
    chk({tag, "_rd"}, 64'(rdata), 64'(exp));
  endtask

  task automatic do_flush();
    @(posedge clk_i); #1;
    flush = 1'b1;
    @(posedge clk_i); #1;
    flush = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0;
    req    = 1'b0;
    we     = 1'b0;
    addr   = '0;
    wdata  = '0;
    be     = '0;
    flush  = 1'b0;

    // Reset state and combinational grant while in reset
    #12;
    chk("rst_vld", 64'(valid), 64'd0);
    chk("rst_rd", 64'(rdata), 64'd0);
    chk("rst_hit", 64'(hit_count), 64'd0);
    chk("rst_miss", 64'(miss_count), 64'd0);
    req = 1'b1;
    #1;
    chk("rst_gnt", 64'(gnt), 64'd1);
    req = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // First lookup after reset misses
    op(1'b0, 6'd3, 34'h1000, 3'b001, 8'h00, 8'h00, "first_lookup");
    chk("first_miss_cnt", 64'(miss_count), 64'd1);
    chk("first_hit_cnt", 64'(hit_count), 64'd0);

    // Fill with RW, then permission/domain checks
    op(1'b1, 6'd3, 34'h1000, 3'b000, 8'h03, 8'h00, "fill_rw");
    op(1'b0, 6'd3, 34'h1ABC, 3'b010, 8'h00, 8'h01, "lkp_w");
    op(1'b0, 6'd3, 34'h1000, 3'b100, 8'h00, 8'h00, "lkp_x");
    op(1'b0, 6'd4, 34'h1000, 3'b001, 8'h00, 8'h00, "lkp_sdid4");
    chk("perm_hit_cnt", 64'(hit_count), 64'd1);
    chk("perm_miss_cnt", 64'(miss_count), 64'd3);

    // Nine fills into eight entries: page 1 is evicted from entry 0
    do_flush();
    for (int k = 1; k <= 9; k++)
      op(1'b1, 6'd5, 34'(k) << 12, 3'b000, 8'h07, 8'h00, "evict_fill");
    op(1'b0, 6'd5, 34'h1000, 3'b001, 8'h00, 8'h00, "evicted_pg1");
    for (int k = 2; k <= 9; k++)
      op(1'b0, 6'd5, 34'(k) << 12, 3'b001, 8'h00, 8'h01, "kept_pg");
    // Victim pointer now at 1: next miss-fill replaces page 2
    op(1'b1, 6'd5, 34'hA000, 3'b000, 8'h07, 8'h00, "fill_pg10");
    op(1'b0, 6'd5, 34'h2000, 3'b001, 8'h00, 8'h00, "evicted_pg2");
    op(1'b0, 6'd5, 34'h3000, 3'b001, 8'h00, 8'h01, "kept_pg3");
    chk("evict_hit_cnt", 64'(hit_count), 64'd10);
    chk("evict_miss_cnt", 64'(miss_count), 64'd5);

    // Back-to-back fill then lookup of the same tag
    @(posedge clk_i); #1;
    set_req(1'b1, 6'd7, 34'h20000, 3'b000, 8'h01);
    @(negedge clk_i);
    chk("b2b_fill_gnt", 64'(gnt), 64'd1);
    @(posedge clk_i); #1;
    set_req(1'b0, 6'd7, 34'h20000, 3'b001, 8'h00);
    chk("b2b_fill_vld", 64'(valid), 64'd1);
    chk("b2b_fill_rd", 64'(rdata), 64'd0);
    @(negedge clk_i);
    chk("b2b_lkp_gnt", 64'(gnt), 64'd1);
    @(posedge clk_i); #1;
    req = 1'b0;
    chk("b2b_lkp_vld", 64'(valid), 64'd1);
    chk("b2b_lkp_rd", 64'(rdata), 64'd1);
    @(posedge clk_i); #1;
    chk("b2b_idle_vld", 64'(valid), 64'd0);

    // Flush with request high: pending response survives, new request blocked
    set_req(1'b0, 6'd7, 34'h20000, 3'b001, 8'h00);
    @(posedge clk_i); #1;
    flush = 1'b1;
    chk("flush_prev_vld", 64'(valid), 64'd1);
    chk("flush_prev_rd", 64'(rdata), 64'd1);
    @(negedge clk_i);
    chk("flush_gnt", 64'(gnt), 64'd0);
    @(posedge clk_i); #1;
    flush = 1'b0;
    req   = 1'b0;
    chk("flush_no_rsp", 64'(valid), 64'd0);
    chk("flush_hit_cnt", 64'(hit_count), 64'd12);
    chk("flush_miss_cnt", 64'(miss_count), 64'd5);
    op(1'b0, 6'd7, 34'h20000, 3'b001, 8'h00, 8'h00, "post_flush");
    chk("post_flush_miss", 64'(miss_count), 64'd6);

    // Reset in the middle of a response
    op(1'b1, 6'd1, 34'h1000, 3'b000, 8'h07, 8'h00, "pre_rst_fill");
    @(posedge clk_i); #1;
    set_req(1'b0, 6'd1, 34'h1000, 3'b111, 8'h00);
    @(posedge clk_i); #1;
    req = 1'b0;
    chk("pre_rst_vld", 64'(valid), 64'd1);
    chk("pre_rst_rd", 64'(rdata), 64'd1);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_vld", 64'(valid), 64'd0);
    chk("mid_rst_hit", 64'(hit_count), 64'd0);
    chk("mid_rst_miss", 64'(miss_count), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    op(1'b0, 6'd1, 34'h1000, 3'b001, 8'h00, 8'h00, "post_rst");
    chk("post_rst_miss", 64'(miss_count), 64'd1);
    chk("post_rst_hit", 64'(hit_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/plb_cache_responder.md
PLB_CACHE_RESPONDER -- requirements
Module: plb_cache_responder

Interface
REQ-001 Parameter PLB_ENTRIES, default 8: number of fully associative entries; power of two, minimum 2.
REQ-002 Parameter SDID_WIDTH, default 6: supervisor domain ID width.
REQ-003 Parameter SPA_WIDTH, default 34: supervisor physical address width; page number is spa[SPA_WIDTH-1:12].
REQ-004 Parameter ACCESS_WIDTH, default 3: access/permission bitmask; bit0=R, bit1=W, bit2=X.
REQ-005 Parameter DATA_WIDTH, default 8: read/write data width.
REQ-006 Derived ADDR_WIDTH = SDID_WIDTH+SPA_WIDTH+ACCESS_WIDTH; addr packs {SDID, spa, access_type}, MSB to LSB.
REQ-007 Port clk_i, input, 1: the single clock.
REQ-008 Port rst_ni, input, 1: asynchronous, active-low reset.
REQ-009 Port plb_cache_mem_req, input, 1: request.
REQ-010 Port plb_cache_mem_gnt, output, 1: request accepted this cycle.
REQ-011 Port plb_cache_mem_addr, input, ADDR_WIDTH: packed lookup/fill tag.
REQ-012 Port plb_cache_mem_we, input, 1: 1 = fill, 0 = lookup.
REQ-013 Port plb_cache_mem_wdata, input, DATA_WIDTH: fill permissions in [ACCESS_WIDTH-1:0].
REQ-014 Port plb_cache_mem_be, input, DATA_WIDTH/8: ignored.
REQ-015 Port plb_cache_mem_valid, output, 1: response valid.
REQ-016 Port plb_cache_mem_rdata, output, DATA_WIDTH: bit0 = hit; other bits 0.
REQ-017 Port flush_i, input, 1: invalidate all entries.
REQ-018 Port hit_count_o / miss_count_o, output, 32 each: lookup statistics.

Function
REQ-019 gnt SHALL be combinational: req && !flush_i; there is no other backpressure.
REQ-020 Each grant SHALL produce exactly one response: valid high for one cycle in the cycle after the grant (latency 1), including back-to-back grants.
REQ-021 Lookup hit: some entry has valid && SDID match && page-number match && (access_type & ~perm) == 0.
REQ-022 Lookup response: rdata[0]=hit; evaluated against array state before the clock edge that ends the grant cycle.
REQ-023 Fill to an existing SDID+page entry: overwrite perm with wdata[ACCESS_WIDTH-1:0].
REQ-024 Fill with no matching entry: write the lowest-index invalid entry; if none is invalid, write the entry at victim pointer, then advance the pointer by 1 modulo PLB_ENTRIES (wraps from PLB_ENTRIES-1 to 0).
REQ-025 Fill response: valid pulse with rdata = 0.
REQ-026 A fill granted in cycle N SHALL be visible to a lookup granted in cycle N+1.
REQ-027 Multiple matching entries are impossible by construction (REQ-023); hit is the OR over entries.
REQ-028 flush_i SHALL clear all valid bits and the victim pointer at the next edge; a request in a flush cycle is not granted and produces no response.
REQ-029 A response already pending from cycle N-1 SHALL still be delivered in a flush cycle N.
REQ-030 hit_count_o / miss_count_o SHALL increment on each granted lookup by outcome, saturating at 2^32-1; fills do not count; flush does not clear them.

Reset
REQ-031 On rst_ni low, asynchronously: all entry valid bits 0, victim pointer 0, valid 0, rdata 0, both counters 0; any pending response is dropped.
REQ-032 gnt SHALL follow REQ-019 during and after reset.
REQ-033 The first grant after reset deassertion SHALL behave normally.

Verification
REQ-034 Lookup SDID=3, spa=0x1000, acc=R after reset -> gnt=1, next cycle valid=1, rdata=0x00, miss_count=1.
REQ-035 Fill SDID=3, spa=0x1000, wdata=0x3; then lookup SDID=3, spa=0x1ABC, acc=W -> rdata=0x01. Lookup acc=X -> rdata=0x00. Lookup SDID=4, spa=0x1000, acc=R -> 0x00.
REQ-036 Fill 9 distinct pages (PLB_ENTRIES=8) -> 9th fill evicts entry 0; first page now misses; pages 2..9 hit; victim pointer = 1.
REQ-037 Back-to-back: fill in cycle N, lookup of the same tag in cycle N+1 -> valid in N+1 and N+2, second rdata=0x01.
REQ-038 flush_i with req high -> gnt=0; the prior cycle's response is still delivered; subsequent lookup of a previously filled tag -> miss; counters unchanged by flush.
REQ-039 Assert rst_ni low mid-response -> valid drops immediately; all entries miss afterwards; counters read 0.
